// File: rtl/alu_defs.sv
// Shared definitions for the ALU share arbiter: opcodes, FSM states,
// and an opcode legality helper used by the optional error flag.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // True when the code is one the ALU actually implements.
  function automatic logic op_legal(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Existing 32-bit combinational ALU. Unknown opcodes produce 0.
module alu
  import alu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // Opcode decode; SLT is an unsigned compare.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'd0, (a < b)};
      ALU_NOR: result = ~(a | b);
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1 with wrap-around.
// winner is valid whenever any req bit is set, independent of enable, so
// the operand mux can settle before the grant is qualified.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] onehot;
  logic [ID_W-1:0]    enc [NUM_REQ];
  logic [ID_W-1:0]    acc [NUM_REQ];

  // Requesters strictly above the last grant get first priority.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign mask[gi] = (32'(last_grant) < 32'(gi));
    end
  endgenerate

  assign hi_req = req & mask;
  assign pick   = (|hi_req) ? hi_req : req;
  // Isolate the lowest set bit of the chosen half.
  assign onehot = pick & (~pick + ONE);
  assign grant  = enable ? onehot : '0;

  // One-hot to binary encode as an OR chain.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc
      assign enc[gi] = onehot[gi] ? ID_W'(gi) : '0;
      if (gi == 0) begin : g_first
        assign acc[gi] = enc[gi];
      end else begin : g_rest
        assign acc[gi] = acc[gi-1] | enc[gi];
      end
    end
  endgenerate

  assign winner = acc[NUM_REQ-1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// single registered response slot. Optional macro ALU_ARB_ILLEGAL_OP_EN adds
// an rsp_err output flagging unimplemented opcodes.
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero
`ifdef ALU_ARB_ILLEGAL_OP_EN
  ,
  output logic                  rsp_err
`endif
);

  localparam int              SLOTS     = 1 << ID_W;
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] last_grant_reg;
  logic [ID_W-1:0] id_reg;
  logic [31:0]     result_reg;
  logic            zero_reg;

  logic               can_acc;
  logic               transfer;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;

  logic [3:0]  op_arr [SLOTS];
  logic [31:0] a_arr  [SLOTS];
  logic [31:0] b_arr  [SLOTS];
  logic [3:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  // Unpack the flat request buses; unused ID codes read as zero.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
        assign op_arr[gi] = req_op[4*gi +: 4];
        assign a_arr[gi]  = req_a[32*gi +: 32];
        assign b_arr[gi]  = req_b[32*gi +: 32];
      end else begin : g_pad
        assign op_arr[gi] = 4'd0;
        assign a_arr[gi]  = 32'd0;
        assign b_arr[gi]  = 32'd0;
      end
    end
  endgenerate

  // The slot can take a new result when empty or being drained this cycle.
  assign can_acc = (state_reg == ST_IDLE) || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .enable     (can_acc),
    .grant      (grant),
    .winner     (winner)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  assign sel_op = op_arr[winner];
  assign sel_a  = a_arr[winner];
  assign sel_b  = b_arr[winner];

  alu u_alu (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a grant always fills the slot; a drain without grant empties it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (transfer) state_next = ST_HOLD;
      ST_HOLD: begin
        if (transfer)       state_next = ST_HOLD;
        else if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response slot and round-robin pointer load on every request transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= LAST_INIT;
      id_reg         <= '0;
      result_reg     <= 32'd0;
      zero_reg       <= 1'b0;
    end else if (transfer) begin
      last_grant_reg <= winner;
      id_reg         <= winner;
      result_reg     <= alu_result;
      zero_reg       <= alu_zero;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic err_reg;

  // Error flag travels with the result it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (transfer) begin
      err_reg <= ~op_legal(sel_op);
    end
  end

  assign rsp_err = err_reg;
`endif

  assign rsp_valid  = (state_reg == ST_HOLD);
  assign rsp_id     = id_reg;
  assign rsp_result = result_reg;
  assign rsp_zero   = zero_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a scoreboard of expected
// responses and a reference round-robin/ALU model.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                  rsp_err;
`endif

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_last;
  bit   m_hold;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [3:0] op);
    return !(op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7 || op == 4'd12);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*4 +: 4]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // One clock cycle: check at the negedge against the model, then advance.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready;
    logic [3:0]         op;
    logic [31:0]        a, b, r;
    exp_t               e;
    bit                 can_acc;
    int                 w;
    @(negedge clk);
    can_acc = !m_hold || rsp_ready;
    w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (m_last + k) % NUM_REQ;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    exp_ready = '0;
    if (can_acc && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
    if (m_hold) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb[0];
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
        if (rsp_ready) begin
          void'(sb.pop_front());
          $display("rsp id=%0d result=0x%08h zero=%0d", rsp_id, rsp_result, rsp_zero);
        end
      end
    end
    if (exp_ready != '0) begin
      op = req_op[w*4 +: 4];
      a  = req_a[w*32 +: 32];
      b  = req_b[w*32 +: 32];
      r  = ref_alu(op, a, b);
      e.id   = 8'(w);
      e.res  = r;
      e.zero = (r == 32'd0);
      e.err  = ref_illegal(op);
      sb.push_back(e);
      m_last = w;
      m_hold = 1'b1;
    end else if (rsp_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    m_last    = NUM_REQ - 1;
    m_hold    = 1'b0;

    // Reset state, checked before any clock edge.
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single op: 0xFFFFFFFF + 1 wraps to zero.
    rsp_ready = 1'b1;
    set_req(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();

    // Round-robin with both requesters continuously valid, no bubble.
    set_req(0, 4'd2, 32'd100, 32'd23);
    set_req(1, 4'd6, 32'd100, 32'd23);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) cycle();
    req_valid = 2'b00;
    cycle();

    // Backpressure: fill the slot, then hold rsp_ready low with req1 waiting.
    rsp_ready = 1'b0;
    set_req(0, 4'd1, 32'd3, 32'd4);
    req_valid = 2'b01;
    cycle();
    set_req(1, 4'd6, 32'd5, 32'd7);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) cycle();
    rsp_ready = 1'b1;
    cycle();
    req_valid = 2'b00;
    cycle();

    // Op coverage through requester 1, including illegal op 3.
    req_valid = 2'b10;
    set_req(1, 4'd0,  32'h0000_F0F0, 32'h00FF_00FF); cycle();
    set_req(1, 4'd1,  32'h0000_F0F0, 32'h00FF_00FF); cycle();
    set_req(1, 4'd12, 32'h0000_F0F0, 32'h00FF_00FF); cycle();
    set_req(1, 4'd7,  32'hFFFF_FFFF, 32'd1);         cycle();
    set_req(1, 4'd7,  32'd1,         32'hFFFF_FFFF); cycle();
    set_req(1, 4'd3,  32'h1234_5678, 32'h1);         cycle();
    set_req(1, 4'd2,  32'h7FFF_FFFF, 32'd1);         cycle();
    req_valid = 2'b00;
    cycle();

    // Reset mid-HOLD: rsp_valid must drop without a clock edge.
    rsp_ready = 1'b0;
    set_req(0, 4'd2, 32'd1, 32'd1);
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    chk("hold_before_reset", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_result", rsp_result, 32'd0);
    chk("async_reset_id", 32'(rsp_id), 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("async_reset_err", 32'(rsp_err), 32'd0);
`endif
    m_hold = 1'b0;
    m_last = NUM_REQ - 1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 32'hAAAA_5555, 32'hFFFF_0000);
    set_req(1, 4'd1, 32'h0000_0F0F, 32'h0F00_0000);
    req_valid = 2'b11;
    #1;
    chk("first_grant_after_reset", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    req_valid = 2'b00;

    // Drain with a bounded number of cycles.
    for (int i = 0; i < 4 && m_hold; i++) cycle();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit combinational ALU among NUM_REQ requesters, e.g. the EX stage, the branch comparator and the address-calculation unit.
- Each request uses a valid/ready handshake. A round-robin arbiter grants at most one request per cycle.
- The granted operation goes through the ALU, and the result is registered into a single response slot tagged with the requester ID.
- Sits between the pipeline stages and the ALU instance. The ALU itself stays unmodified.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; at most one bit set (one-hot or zero).
- req_op  input  4*NUM_REQ  ALUControl code per requester; requester i uses bits [4i+3:4i].
- req_a  input  32*NUM_REQ  operand A per requester; requester i uses bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B per requester; requester i uses bits [32i+31:32i].
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that produced the response.
- rsp_result  output  32  registered ALU result.
- rsp_zero  output  1  registered (result == 0).

Behaviour:
ALU operation codes (applied to the granted operands):
- 0 = AND; 1 = OR; 2 = ADD (mod 2^32).
- 6 = SUB (mod 2^32).
- 7 = SLT, unsigned compare: result 1 if A < B, else 0.
- 12 = NOR.
- Any other code: result 0, zero 1.

State machine:
- Two states, IDLE (slot empty) and HOLD (slot full); rsp_valid = (state == HOLD).
- Slot can accept a request: can_acc = IDLE | (HOLD & rsp_ready).

Arbitration:
- Round-robin among the asserted req_valid bits, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
- req_ready[winner] = can_acc & req_valid[winner]. req_ready is combinational; all other bits are 0.
- A requester must hold valid, op and operands stable until its ready is seen.

Handshake and transitions:
- A request transfers on the cycle where req_valid[i] & req_ready[i].
- A response completes on the cycle where rsp_valid & rsp_ready.
- On a request transfer, at the clock edge: rsp_result, rsp_zero and rsp_id load from the ALU output and the winner index; last_grant <= winner; state <= HOLD.
- Simultaneous response completion and new grant: the slot reloads with the new result and stays in HOLD. This gives 1 op/cycle throughput with no bubble.
- Response completes with no new grant: state <= IDLE. rsp_result, rsp_zero and rsp_id keep their old values, but they are don't-care while rsp_valid is 0.
- HOLD & !rsp_ready: all rsp_* outputs hold stable and every req_ready bit is 0 (backpressure).

Timing and reset:
- Latency: the request transfers in cycle N; rsp_valid is 1 in cycle N+1.
- Reset, asynchronous and legal at any time including mid-HOLD:
  - state = IDLE, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_id = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Any pending response is discarded.
- req_valid bits above NUM_REQ-1 do not exist. A requester that drops valid before being granted is not served.

Optional Feature:
- Macro ALU_ARB_ILLEGAL_OP_EN.
- When defined:
  - Adds output port rsp_err (1 bit, reset 0), registered alongside rsp_result.
  - rsp_err is 1 when the granted op is not in {0,1,2,6,7,12}; result and zero still follow the default rule (0 / 1).
- When undefined: no rsp_err port, and illegal ops silently return 0.

Decomposition:
- Shared package/include file alu_defs:
  - ALU opcode constants ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
  - State encodings ST_IDLE, ST_HOLD.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ; inputs req vector, last_grant and enable; outputs one-hot grant and the encoded winner index.
- The existing ALU is instantiated once, with its inputs muxed by the winner index.

Test Plan:
- Single op: after reset, req0 with op=2, A=0xFFFFFFFF, B=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0, rsp_zero=1.
- Round-robin: both requesters valid continuously, rsp_ready=1 -> grant order 0,1,0,1; rsp_valid stays 1 every cycle after the first (no bubble).
- Backpressure: hold rsp_ready=0 for 3 cycles with req1 valid (op=6, A=5, B=7) -> req_ready=0 throughout and rsp_* unchanged; raising rsp_ready grants req1, giving result 0xFFFFFFFE next cycle.
- Op coverage via requester 1, with A=0x0000F0F0, B=0x00FF00FF:
  - op 0 -> 0x000000F0; op 1 -> 0x00FFF0FF; op 12 -> 0xFF000F00.
  - op 7 with A=0xFFFFFFFF, B=1 -> 0 (unsigned compare).
- Illegal op 3 -> result 0, zero 1; with ALU_ARB_ILLEGAL_OP_EN also rsp_err=1.
- Reset mid-HOLD: assert reset while rsp_valid=1 -> rsp_valid drops immediately (asynchronously), without waiting for a clock edge; after release, with both requesters valid, requester 0 is granted first.
